// File: rtl/wave_capture_if.sv
// Capture sequencer bus: ADC stream, trigger controls and display read port.
interface wave_capture_if;
    logic        adc_valid;
    logic [7:0]  adc_data;
    logic        run;
    logic        trig_mode;
    logic        trig_edge;
    logic [7:0]  trig_level;
    logic [7:0]  decim;
    logic        frame_start;
    logic [10:0] x;
    logic [7:0]  sample_8b;
    logic [1:0]  state;
    logic        swapped;
    logic        auto_fired;

    modport master (
        output adc_valid, adc_data, run, trig_mode, trig_edge, trig_level, decim, frame_start, x,
        input  sample_8b, state, swapped, auto_fired
    );

    modport slave (
        input  adc_valid, adc_data, run, trig_mode, trig_edge, trig_level, decim, frame_start, x,
        output sample_8b, state, swapped, auto_fired
    );
endinterface

// File: rtl/wave_capture_ctrl.sv
// Trigger/capture sequencer: decimates ADC samples, detects a level/edge trigger and fills the back half
// of a ping-pong buffer; halves swap only at frame_start so the display never tears.
module wave_capture_ctrl #(
    parameter int unsigned H_VALID    = 800,
    parameter int unsigned AW         = 10,
    parameter int unsigned AUTO_TMO   = 4096,
    parameter logic [7:0]  IDLE_LEVEL = 8'h80
) (
    input logic           pclk,
    input logic           rst_n,
    wave_capture_if.slave bus
);
    localparam int unsigned TW   = $clog2(AUTO_TMO + 1);
    localparam logic [10:0] XLIM = 11'(H_VALID);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_TRIG = 2'd1,
        S_CAPTURE   = 2'd2,
        S_DONE      = 2'd3
    } state_t;

    state_t          r_state, w_next;
    logic [7:0]      r_dcnt, r_decim_q, r_prev;
    logic            r_have_prev;
    logic [TW-1:0]   r_tmo;
    logic [AW-1:0]   r_waddr, w_waddr;
    logic            r_front_sel, r_buf_valid, r_auto_q, r_auto_fired, r_swapped;
    logic [7:0]      r_ram [0:(2**(AW+1))-1];
    logic [7:0]      r_rdata;
    logic            r_rd_ok;

    logic w_active, w_taken, w_rise, w_fall, w_trig, w_tmo_hit, w_last, w_swap;
    logic w_arm, w_start, w_we;

    assign w_active  = (r_state == S_WAIT_TRIG) || (r_state == S_CAPTURE);
    assign w_taken   = w_active && bus.adc_valid && (r_dcnt == r_decim_q);
    assign w_rise    = (r_prev < bus.trig_level) && (bus.adc_data >= bus.trig_level);
    assign w_fall    = (r_prev > bus.trig_level) && (bus.adc_data <= bus.trig_level);
    assign w_trig    = w_taken && r_have_prev && (bus.trig_edge ? w_fall : w_rise);
    assign w_tmo_hit = w_taken && !bus.trig_mode && (r_tmo == TW'(AUTO_TMO - 1));
    assign w_last    = (r_waddr == AW'(H_VALID - 1));
    assign w_swap    = (r_state == S_DONE) && bus.frame_start;
    assign w_waddr   = w_start ? '0 : r_waddr;

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_arm   = 1'b0;
        w_start = 1'b0;
        w_we    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.run) begin
                    w_next = S_WAIT_TRIG;
                    w_arm  = 1'b1;
                end
            end
            S_WAIT_TRIG: begin
                if (!bus.run) begin
                    w_next = S_IDLE;
                end else if (w_trig || w_tmo_hit) begin
                    w_next  = S_CAPTURE;
                    w_start = 1'b1;
                    w_we    = 1'b1;
                end
            end
            S_CAPTURE: begin
                if (w_taken) begin
                    w_we = 1'b1;
                    if (w_last) w_next = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.frame_start) begin
                    w_next = bus.run ? S_WAIT_TRIG : S_IDLE;
                    w_arm  = bus.run;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_dcnt       <= '0;
            r_decim_q    <= '0;
            r_prev       <= '0;
            r_have_prev  <= 1'b0;
            r_tmo        <= '0;
            r_waddr      <= '0;
            r_front_sel  <= 1'b0;
            r_buf_valid  <= 1'b0;
            r_auto_q     <= 1'b0;
            r_auto_fired <= 1'b0;
            r_swapped    <= 1'b0;
            r_rd_ok      <= 1'b0;
        end else begin
            r_swapped <= w_swap;
            r_rd_ok   <= r_buf_valid && (bus.x < XLIM);
            if (w_arm) begin
                r_dcnt      <= '0;
                r_tmo       <= '0;
                r_waddr     <= '0;
                r_have_prev <= 1'b0;
                r_decim_q   <= bus.decim;
            end else begin
                if (w_active && bus.adc_valid)
                    r_dcnt <= w_taken ? '0 : r_dcnt + 8'd1;
                if ((r_state == S_WAIT_TRIG) && w_taken) begin
                    r_prev      <= bus.adc_data;
                    r_have_prev <= 1'b1;
                    r_tmo       <= r_tmo + TW'(1);
                end
                if (w_we) r_waddr <= w_waddr + AW'(1);
            end
            // a trigger arriving together with the timeout still counts as a real trigger
            if (w_start) r_auto_q <= !w_trig;
            if (w_swap) begin
                r_front_sel  <= ~r_front_sel;
                r_buf_valid  <= 1'b1;
                r_auto_fired <= r_auto_q;
            end
        end
    end

    // Unreset RAM: writes go to the back half, reads come from the front half.
    always_ff @(posedge pclk) begin
        if (w_we) r_ram[{~r_front_sel, w_waddr}] <= bus.adc_data;
        r_rdata <= r_ram[{r_front_sel, bus.x[AW-1:0]}];
    end

    assign bus.sample_8b  = r_rd_ok ? r_rdata : IDLE_LEVEL;
    assign bus.state      = r_state;
    assign bus.swapped    = r_swapped;
    assign bus.auto_fired = r_auto_fired;
endmodule
